// File: rtl/seq_signed_mult.sv
// Iterative shift-add multiplier with runtime signed/unsigned selection and sign restoration.
// Optional build macro SEQ_MULT_EARLY_TERM_EN: leave CALC as soon as the multiplier magnitude is exhausted.
module seq_signed_mult #(
  parameter int DW   = 8,
  parameter int DW_2 = 2 * DW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            signed_mode,
  input  logic [DW-1:0]   multiplier,
  input  logic [DW-1:0]   multiplicand,
  output logic            ready,
  output logic            done,
  output logic [DW_2-1:0] product,
  output logic            sign
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   mplier;
  logic [DW-1:0]   mplier_shift;
  logic [DW_2-1:0] mcand;
  logic [DW_2-1:0] acc;
  logic [CW-1:0]   cnt;
  logic            sign_cap;
  logic [DW-1:0]   mag_a, mag_b;
  logic            last_iter;

  // A negative operand becomes its magnitude; the most negative value maps to 2^(DW-1) as unsigned.
  always_comb begin
    mag_a = (signed_mode && multiplier[DW-1])   ? (~multiplier + DW'(1))   : multiplier;
    mag_b = (signed_mode && multiplicand[DW-1]) ? (~multiplicand + DW'(1)) : multiplicand;
  end

  assign mplier_shift = mplier >> 1;

`ifdef SEQ_MULT_EARLY_TERM_EN
  assign last_iter = (cnt == CW'(DW - 1)) || (mplier_shift == '0);
`else
  assign last_iter = (cnt == CW'(DW - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last_iter) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ready = (state == IDLE);
  assign done  = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mplier   <= '0;
      mcand    <= '0;
      acc      <= '0;
      cnt      <= '0;
      sign_cap <= 1'b0;
      product  <= '0;
      sign     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mplier   <= mag_a;
            mcand    <= DW_2'(mag_b);
            acc      <= '0;
            cnt      <= '0;
            sign_cap <= signed_mode & (multiplier[DW-1] ^ multiplicand[DW-1]);
          end
        end
        CALC: begin
          if (mplier[0]) acc <= acc + mcand;
          mplier <= mplier_shift;
          mcand  <= mcand << 1;
          cnt    <= cnt + CW'(1);
        end
        FIX: begin
          // A zero magnitude result stays +0 regardless of operand signs.
          if (sign_cap && (acc != '0)) product <= ~acc + DW_2'(1);
          else                         product <= acc;
          sign <= sign_cap & (acc != '0);
        end
        default: ;
      endcase
    end
  end

endmodule
